// File: rtl/seg595_hex_scan.sv
// rtl/seg595_hex_scan.sv - multiplexed hex display scanner driving two chained 74HC595s
// Optional leading-zero blanking: define SEG595_LZB_EN.
module seg595_hex_scan #(
    parameter int DIGITS          = 8,
    parameter int DIV_W           = 8,
    parameter bit SEG_ACTIVE_LOW  = 1'b1,
    parameter bit SEL_ACTIVE_HIGH = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  enable,
    output logic                  sclk,
    output logic                  sdat,
    output logic                  rclk,
    output logic                  frame_done,
    output logic [2:0]            cur_digit
);

    localparam logic [5:0] LAST_PHASE = 6'd33;
    localparam logic [2:0] LAST_DIGIT = 3'(DIGITS - 1);
    localparam logic [7:0] SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0] SEL_D0     = SEL_ACTIVE_HIGH ? 8'h01 : 8'hFE;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // A digit is a leading zero when it and every nibble above it are zero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v);
        logic [DIGITS-1:0] m;
        logic              seen;
        m    = '0;
        seen = 1'b0;
`ifdef SEG595_LZB_EN
        for (int i = DIGITS - 1; i > 0; i--) begin
            seen = seen | (v[4*i +: 4] != 4'h0);
            m[i] = ~seen;
        end
`else
        seen = |v;
        m    = '0;
`endif
        return m;
    endfunction

    function automatic logic [15:0] make_word(
        input logic [2:0]          dg,
        input logic [4*DIGITS-1:0] v,
        input logic [DIGITS-1:0]   d,
        input logic [DIGITS-1:0]   b,
        input logic [DIGITS-1:0]   lz,
        input logic                en
    );
        logic [7:0] seg;
        logic [7:0] sel;
        int         idx;
        idx = int'(dg);
        if (!en || b[idx]) begin
            seg = 8'hFF;
        end else begin
            seg[6:0] = lz[idx] ? 7'h7F : glyph(v[4*idx +: 4]);
            seg[7]   = ~d[idx];
        end
        if (!SEG_ACTIVE_LOW) seg = ~seg;
        sel = en ? (8'd1 << dg) : 8'd0;
        if (!SEL_ACTIVE_HIGH) sel = ~sel;
        return {seg, sel};
    endfunction

    logic [DIV_W-1:0]  div;
    logic [5:0]        phase, phase_nxt;
    logic [2:0]        digit_nxt;
    logic [15:0]       word, word_nxt;
    logic [4*DIGITS-1:0] snap_value;
    logic [DIGITS-1:0] snap_dp, snap_blank, snap_lz;
    logic              tick, frame_wrap;
    logic              sclk_nxt, sdat_nxt, rclk_nxt;

    assign tick       = &div;
    assign frame_wrap = tick && (phase == LAST_PHASE) && (cur_digit == LAST_DIGIT);

    always_comb begin
        phase_nxt = phase;
        digit_nxt = cur_digit;
        word_nxt  = word;
        if (tick) begin
            if (phase == LAST_PHASE) begin
                phase_nxt = 6'd0;
                digit_nxt = (cur_digit == LAST_DIGIT) ? 3'd0 : cur_digit + 3'd1;
                // The first digit of a frame must already see the snapshot being taken now.
                if (frame_wrap)
                    word_nxt = make_word(3'd0, value, dp, blank, lz_mask(value), enable);
                else
                    word_nxt = make_word(digit_nxt, snap_value, snap_dp, snap_blank, snap_lz, enable);
            end else begin
                phase_nxt = phase + 6'd1;
            end
        end
    end

    always_comb begin
        sclk_nxt = 1'b0;
        sdat_nxt = word[0];
        rclk_nxt = 1'b0;
        if (phase < 6'd32) begin
            sclk_nxt = phase[0];
            sdat_nxt = word[4'd15 - phase[4:1]];
        end else if (phase == 6'd32) begin
            rclk_nxt = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div        <= '0;
            phase      <= '0;
            cur_digit  <= '0;
            word       <= {SEG_OFF, SEL_D0};
            snap_value <= '0;
            snap_dp    <= '0;
            snap_blank <= '1;
            snap_lz    <= '0;
            sclk       <= 1'b0;
            sdat       <= 1'b0;
            rclk       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            div        <= div + 1'b1;
            phase      <= phase_nxt;
            cur_digit  <= digit_nxt;
            word       <= word_nxt;
            sclk       <= sclk_nxt;
            sdat       <= sdat_nxt;
            rclk       <= rclk_nxt;
            frame_done <= frame_wrap;
            if (frame_wrap) begin
                snap_value <= value;
                snap_dp    <= dp;
                snap_blank <= blank;
                snap_lz    <= lz_mask(value);
            end
        end
    end

endmodule

// File: tb/tb_seg595_hex_scan.sv
// tb/tb_seg595_hex_scan.sv - directed self-checking bench for seg595_hex_scan (DIGITS=8, DIV_W=2)
module tb_seg595_hex_scan;

    localparam int FRAME = 8 * 34 * 4;
    localparam int DIG   = 34 * 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp = '0;
    logic [7:0]  blank = '0;
    logic        enable = 1'b1;
    logic        sclk, sdat, rclk, frame_done;
    logic [2:0]  cur_digit;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] sh = '0;
    logic        sclk_q = 1'b0, rclk_q = 1'b0;
    logic [15:0] words[$];
    int          fd_q[$];
    logic [15:0] exp_w[8];

    seg595_hex_scan #(.DIGITS(8), .DIV_W(2), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_HIGH(1'b1)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .value(value), .dp(dp), .blank(blank),
        .enable(enable), .sclk(sclk), .sdat(sdat), .rclk(rclk), .frame_done(frame_done),
        .cur_digit(cur_digit)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    // Rebuild each shifted word from the serial pins; latch it on the storage strobe.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            sh     <= '0;
            sclk_q <= 1'b0;
            rclk_q <= 1'b0;
        end else begin
            if (sclk && !sclk_q) sh <= {sh[14:0], sdat};
            if (rclk && !rclk_q) words.push_back(sh);
            if (frame_done) fd_q.push_back(cyc);
            sclk_q <= sclk;
            rclk_q <= rclk;
        end
    end

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        words.delete();
        fd_q.delete();
        sys_rst_n = 1'b1;
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (words.size() < n && t < 6000) begin
            @(posedge sys_clk);
            t++;
        end
        checks++;
        if (words.size() < n) begin
            errors++;
            $display("FAIL wait_words got %0d words required %0d", words.size(), n);
            while (words.size() < n) words.push_back(16'hxxxx);
        end
    endtask

    task automatic wait_cyc(input int n);
        int t = 0;
        while (cyc < n && t < 10000) begin
            @(posedge sys_clk);
            t++;
        end
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        value = '0; dp = '0; blank = '0; enable = 1'b1;
        repeat (2) @(negedge sys_clk);
        checks += 5;
        if (sclk !== 1'b0)       begin errors++; $display("FAIL reset_sclk got %b exp 0", sclk); end
        if (sdat !== 1'b0)       begin errors++; $display("FAIL reset_sdat got %b exp 0", sdat); end
        if (rclk !== 1'b0)       begin errors++; $display("FAIL reset_rclk got %b exp 0", rclk); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
        if (cur_digit !== 3'd0)  begin errors++; $display("FAIL reset_cur_digit got %0d exp 0", cur_digit); end
        do_reset();
        value = 32'h76543210;
        wait_cyc(FRAME + 6);
        checks++;
        if (words.size() !== 8) begin errors++; $display("FAIL frame1_rclk_count got %0d exp 8", words.size()); end
        checks++;
        if (fd_q.size() !== 1) begin errors++; $display("FAIL frame1_done_count got %0d exp 1", fd_q.size());
        end else begin
            checks++;
            if (fd_q[0] !== FRAME) begin errors++; $display("FAIL frame1_done_cycle got %0d exp %0d", fd_q[0], FRAME); end
        end
        wait_words(8);
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (words[d] !== (16'hFF00 | (16'h1 << d)))
                begin errors++; $display("FAIL frame1_dark d%0d got %h exp %h", d, words[d], 16'hFF00 | (16'h1 << d)); end
        end
    endtask

    task automatic test_pattern();
        exp_w = '{16'hC001, 16'hF902, 16'hA404, 16'hB008, 16'h9910, 16'h9220, 16'h8240, 16'hF880};
        do_reset();
        value = 32'h76543210; dp = '0; blank = '0; enable = 1'b1;
        wait_words(16);
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (words[8+d] !== exp_w[d])
                begin errors++; $display("FAIL pattern d%0d got %h exp %h", d, words[8+d], exp_w[d]); end
        end
    endtask

    task automatic test_dp_blank();
        do_reset();
        value = 32'h00000800; dp = 8'h04; blank = '0;
        wait_words(16);
        checks++;
        if (words[10] !== 16'h0004) begin errors++; $display("FAIL dp_digit2 got %h exp 0004", words[10]); end
        checks++;
        if (words[8] !== 16'hC001) begin errors++; $display("FAIL dp_digit0 got %h exp C001", words[8]); end
        do_reset();
        dp = 8'h00; blank = 8'h04;
        wait_words(16);
        checks++;
        if (words[10] !== 16'hFF04) begin errors++; $display("FAIL blank_digit2 got %h exp FF04", words[10]); end
        checks++;
        if (words[9] !== 16'hC002) begin errors++; $display("FAIL blank_digit1 got %h exp C002", words[9]); end
        blank = '0;
    endtask

    task automatic test_midframe();
        do_reset();
        value = 32'h11111111;
        wait_cyc(FRAME + 500);
        value = 32'h22222222;
        wait_words(24);
        checks += 4;
        if (words[8]  !== 16'hF901) begin errors++; $display("FAIL mid_f2d0 got %h exp F901", words[8]); end
        if (words[15] !== 16'hF980) begin errors++; $display("FAIL mid_f2d7 got %h exp F980", words[15]); end
        if (words[16] !== 16'hA401) begin errors++; $display("FAIL mid_f3d0 got %h exp A401", words[16]); end
        if (words[23] !== 16'hA480) begin errors++; $display("FAIL mid_f3d7 got %h exp A480", words[23]); end
    endtask

    task automatic test_enable();
        do_reset();
        value = 32'h76543210; enable = 1'b1;
        wait_cyc(FRAME + 2*DIG + 50);
        enable = 1'b0;
        wait_cyc(FRAME + 7*DIG + 50);
        enable = 1'b1;
        wait_words(17);
        checks++;
        if (words[10] !== 16'hA404) begin errors++; $display("FAIL en_digit2 got %h exp A404", words[10]); end
        for (int d = 3; d < 8; d++) begin
            checks++;
            if (words[8+d] !== 16'hFF00) begin errors++; $display("FAIL en_off d%0d got %h exp FF00", d, words[8+d]); end
        end
        checks++;
        if (words[16] !== 16'hC001) begin errors++; $display("FAIL en_restore got %h exp C001", words[16]); end
    endtask

    task automatic test_lzb();
        do_reset();
        value = 32'h00000A05;
        wait_words(16);
`ifdef SEG595_LZB_EN
        for (int d = 3; d < 8; d++) begin
            checks++;
            if (words[8+d][15:8] !== 8'hFF) begin errors++; $display("FAIL lzb d%0d got %h exp FF", d, words[8+d][15:8]); end
        end
`else
        checks++;
        if (words[15][15:8] !== 8'hC0) begin errors++; $display("FAIL nolzb d7 got %h exp C0", words[15][15:8]); end
`endif
        checks += 3;
        if (words[10][15:8] !== 8'h88) begin errors++; $display("FAIL lzb d2 got %h exp 88", words[10][15:8]); end
        if (words[9][15:8]  !== 8'hC0) begin errors++; $display("FAIL lzb d1 got %h exp C0", words[9][15:8]); end
        if (words[8][15:8]  !== 8'h92) begin errors++; $display("FAIL lzb d0 got %h exp 92", words[8][15:8]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        value = 32'h12345678;
        wait_cyc(FRAME + 2*DIG + 7);
        sys_rst_n = 1'b0;
        #1;
        checks += 3;
        if (sclk !== 1'b0)      begin errors++; $display("FAIL midrst_sclk got %b exp 0", sclk); end
        if (sdat !== 1'b0)      begin errors++; $display("FAIL midrst_sdat got %b exp 0", sdat); end
        if (cur_digit !== 3'd0) begin errors++; $display("FAIL midrst_digit got %0d exp 0", cur_digit); end
        do_reset();
        wait_words(9);
        checks += 2;
        if (words[0] !== 16'hFF01) begin errors++; $display("FAIL midrst_dark got %h exp FF01", words[0]); end
        if (words[8] !== 16'h8001) begin errors++; $display("FAIL midrst_f2d0 got %h exp 8001", words[8]); end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_dp_blank();
        test_midframe();
        test_enable();
        test_lzb();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
